// File: rtl/misr_sig_ctrl.sv
// misr_sig_ctrl: bank of NCH multiple-input signature registers with a
// length-counted run controller. Each channel compacts one WIDTH-bit response
// word per accepted cycle. After the programmed number of words the bank
// stops, holds its signatures and reports a per-channel golden match.
module misr_sig_ctrl #(
    parameter int               WIDTH = 32,
    parameter int               NCH   = 2,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h0001_0811),
    parameter int               CNT_W = 16
) (
    input  logic                   CK,
    input  logic                   RESET,
    input  logic                   start,
    input  logic [CNT_W-1:0]       len,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   data_valid,
    input  logic [NCH*WIDTH-1:0]   data_in,
    input  logic [NCH*WIDTH-1:0]   golden,
    output logic                   busy,
    output logic                   done,
    output logic [NCH*WIDTH-1:0]   sig_out,
    output logic [NCH-1:0]         match,
    output logic                   pass
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_word;
    logic [NCH*WIDTH-1:0] sig_next;

    // One MISR step: shift left, fold in data, and feed the MSB back into
    // bit 0 unconditionally and into every other bit selected by POLY.
    function automatic logic [WIDTH-1:0] misr_step(
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] n;
        logic             fb;
        fb   = s[WIDTH-1];
        n[0] = fb ^ d[0];
        for (int i = 1; i < WIDTH; i++) begin
            n[i] = s[i-1] ^ d[i] ^ (POLY[i] & fb);
        end
        return n;
    endfunction

    // Next signature of every channel, assuming the current word is accepted.
    always_comb begin
        sig_next = sig_out;
        for (int c = 0; c < NCH; c++) begin
            sig_next[c*WIDTH +: WIDTH] = misr_step(sig_out[c*WIDTH +: WIDTH],
                                                   data_in[c*WIDTH +: WIDTH]);
        end
    end

    // Counter lookahead; the run ends on the word that makes count reach len.
    always_comb begin
        cnt_inc   = cnt + CNT_W'(1);
        last_word = (cnt_inc == len_reg);
    end

    // Run controller: state, counter, length and signatures, with busy/done
    // registered alongside the state so they never glitch or overlap.
    always_ff @(posedge CK) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            len_reg <= '0;
            sig_out <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sig_out <= {NCH{seed}};
                        cnt     <= '0;
                        len_reg <= len;
                        if (len == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (data_valid) begin
                        sig_out <= sig_next;
                        cnt     <= cnt_inc;
                        if (last_word) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Golden comparison, only meaningful once the run has finished.
    always_comb begin
        match = '0;
        for (int c = 0; c < NCH; c++) begin
            match[c] = done & (sig_out[c*WIDTH +: WIDTH] == golden[c*WIDTH +: WIDTH]);
        end
        pass = done & (&match);
    end

endmodule

// File: tb/tb_misr_sig_ctrl.sv
// Directed bench for misr_sig_ctrl with default parameters (32-bit, 2 channels).
module tb_misr_sig_ctrl;

    localparam int          W      = 32;
    localparam int          N      = 2;
    localparam int          CW     = 16;
    localparam logic [31:0] POLY_T = 32'h0001_0811;

    logic            CK;
    logic            RESET;
    logic            start;
    logic [CW-1:0]   len;
    logic [W-1:0]    seed;
    logic            data_valid;
    logic [N*W-1:0]  data_in;
    logic [N*W-1:0]  golden;
    logic            busy;
    logic            done;
    logic [N*W-1:0]  sig_out;
    logic [N-1:0]    match;
    logic            pass;

    int checks = 0;
    int errors = 0;

    misr_sig_ctrl dut (
        .CK(CK), .RESET(RESET), .start(start), .len(len), .seed(seed),
        .data_valid(data_valid), .data_in(data_in), .golden(golden),
        .busy(busy), .done(done), .sig_out(sig_out), .match(match), .pass(pass)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Reference step written as shift-and-xor-mask.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ d ^ (s[31] ? (POLY_T | 32'h1) : 32'h0);
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic start_run(input logic [31:0] sd, input logic [CW-1:0] ln);
        start = 1'b1; seed = sd; len = ln;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d0, input logic [31:0] d1);
        data_valid = 1'b1; data_in = {d1, d0};
        tick();
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; start = 1'b1; data_valid = 1'b1; len = 16'd3;
        seed = 32'h1234_5678; data_in = '1; golden = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (sig_out !== 64'h0) begin errors++; $display("FAIL rst_sig got %h want 0", sig_out); end
        checks++; if ({match, pass} !== 3'b000) begin errors++; $display("FAIL rst_match got %b want 000", {match, pass}); end
        RESET = 1'b1; start = 1'b0; data_valid = 1'b0;
        tick();
        checks++; if ({busy, done, match, pass} !== 5'b0 || sig_out !== 64'h0)
            begin errors++; $display("FAIL rst_release got b%b d%b sig %h want all 0", busy, done, sig_out); end
    endtask

    task automatic test_taps();
        start_run(32'h8000_0000, 16'd1);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL taps_busy got b%b d%b want b1 d0", busy, done); end
        checks++; if (sig_out !== {2{32'h8000_0000}}) begin errors++; $display("FAIL taps_seed got %h want 8000000080000000", sig_out); end
        push(32'h0, 32'h0);
        checks++; if (sig_out !== {2{32'h0001_0811}}) begin errors++; $display("FAIL taps_fb got %h want 0001081100010811", sig_out); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL taps_done got b%b d%b want b0 d1", busy, done); end
        start_run(32'h0, 16'd1);
        push(32'h1, 32'h1);
        checks++; if (sig_out !== {2{32'h0000_0001}}) begin errors++; $display("FAIL taps_d0 got %h want 0000000100000001", sig_out); end
    endtask

    task automatic test_gapped();
        // seed 1, ch0 {1,2,4}: 1->3->4->C ; ch1 zeros: 1->2->4->8
        logic [31:0] w [3];
        w[0] = 32'h1; w[1] = 32'h2; w[2] = 32'h4;
        start_run(32'h1, 16'd3);
        for (int i = 0; i < 3; i++) begin
            push(w[i], 32'h0);
            if (i < 2) begin
                tick(); tick();
                checks++; if (busy !== 1'b1 || done !== 1'b0)
                    begin errors++; $display("FAIL gap_busy[%0d] got b%b d%b want b1 d0", i, busy, done); end
            end
        end
        checks++; if (sig_out !== {32'h8, 32'hC}) begin errors++; $display("FAIL gap_sig got %h want 000000080000000c", sig_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got %b want 1", done); end
        // Same words without gaps from a fresh start
        start_run(32'h1, 16'd3);
        for (int i = 0; i < 3; i++) push(w[i], 32'h0);
        checks++; if (sig_out !== {32'h8, 32'hC}) begin errors++; $display("FAIL nogap_sig got %h want 000000080000000c", sig_out); end
    endtask

    task automatic test_len0();
        golden = {32'h0, 32'hDEAD_BEEF};
        start_run(32'hDEAD_BEEF, 16'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done got b%b d%b want b0 d1", busy, done); end
        checks++; if (sig_out !== {2{32'hDEAD_BEEF}}) begin errors++; $display("FAIL len0_sig got %h want deadbeefdeadbeef", sig_out); end
        checks++; if (match !== 2'b01 || pass !== 1'b0) begin errors++; $display("FAIL len0_match got m%b p%b want m01 p0", match, pass); end
        data_valid = 1'b1; data_in = '1;
        tick();
        data_valid = 1'b0;
        checks++; if (sig_out !== {2{32'hDEAD_BEEF}}) begin errors++; $display("FAIL len0_hold got %h want deadbeefdeadbeef", sig_out); end
    endtask

    task automatic test_midrun();
        logic [31:0] s0, s1;
        s0 = 32'hA5A5_0F0F; s1 = 32'hA5A5_0F0F;
        start_run(32'hA5A5_0F0F, 16'd5);
        push(32'h1357_9BDF, 32'h8000_0001);
        s0 = ref_step(s0, 32'h1357_9BDF); s1 = ref_step(s1, 32'h8000_0001);
        start_run(32'h0, 16'd1);
        checks++; if (busy !== 1'b1 || sig_out !== {s1, s0})
            begin errors++; $display("FAIL mid_start got b%b %h want b1 %h", busy, sig_out, {s1, s0}); end
        push(32'hFFFF_0000, 32'h0000_FFFF);
        s0 = ref_step(s0, 32'hFFFF_0000); s1 = ref_step(s1, 32'h0000_FFFF);
        checks++; if (sig_out !== {s1, s0} || busy !== 1'b1)
            begin errors++; $display("FAIL mid_word2 got b%b %h want b1 %h", busy, sig_out, {s1, s0}); end
        RESET = 1'b0; data_valid = 1'b1; data_in = {2{32'h5555_5555}};
        tick();
        RESET = 1'b1; data_valid = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sig_out !== 64'h0)
            begin errors++; $display("FAIL mid_reset got b%b d%b %h want b0 d0 0", busy, done, sig_out); end
        for (int i = 0; i < 3; i++) push(32'h1, 32'h1);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sig_out !== 64'h0)
            begin errors++; $display("FAIL mid_idle got b%b d%b %h want b0 d0 0", busy, done, sig_out); end
    endtask

    task automatic test_pass_restart();
        logic [31:0] w0 [16];
        logic [31:0] w1 [16];
        logic [31:0] g0, g1, sd;
        sd = 32'hC0FF_EE01; g0 = sd; g1 = sd;
        for (int i = 0; i < 16; i++) begin
            w0[i] = $urandom; w1[i] = $urandom;
            g0 = ref_step(g0, w0[i]); g1 = ref_step(g1, w1[i]);
        end
        golden = {g1, g0};
        start_run(sd, 16'd16);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1)
                    begin errors++; $display("FAIL b2b_early got b%b d%b want b1 d0", busy, done); end
            end
            push(w0[i], w1[i]);
        end
        checks++; if (sig_out !== {g1, g0}) begin errors++; $display("FAIL b2b_sig got %h want %h", sig_out, {g1, g0}); end
        checks++; if (pass !== 1'b1 || match !== 2'b11) begin errors++; $display("FAIL b2b_pass got m%b p%b want m11 p1", match, pass); end
        start_run(sd, 16'd16);
        checks++; if (done !== 1'b0 || busy !== 1'b1 || sig_out !== {2{sd}})
            begin errors++; $display("FAIL restart got b%b d%b %h want b1 d0 %h", busy, done, sig_out, {2{sd}}); end
        checks++; if (match !== 2'b00 || pass !== 1'b0) begin errors++; $display("FAIL restart_match got m%b p%b want m00 p0", match, pass); end
        w1[5] = w1[5] ^ 32'h0000_0100;
        for (int i = 0; i < 16; i++) push(w0[i], w1[i]);
        checks++; if (done !== 1'b1 || match !== 2'b01 || pass !== 1'b0)
            begin errors++; $display("FAIL corrupt got d%b m%b p%b want d1 m01 p0", done, match, pass); end
    endtask

    initial begin
        RESET = 1'b0; start = 1'b0; len = '0; seed = '0;
        data_valid = 1'b0; data_in = '0; golden = '0;
        test_reset();
        test_taps();
        test_gapped();
        test_len0();
        test_midrun();
        test_pass_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
